timing_sequence_scheduler: RTL and testbench



---
 rtl/timing_sequence_scheduler_pkg.sv | 23 ++
 rtl/timing_sequence_scheduler_slot_position_counter.sv | 44 ++++
 rtl/timing_sequence_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_timing_sequence_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timing_sequence_scheduler_pkg.sv
// Shared definitions for the DRAM timing-sequence scheduler: FSM state encoding,
// the NOP slot filler and a constant-evaluable ceiling log2.
package timing_sequence_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PLAY  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] NOP_CMD_DEFAULT = 8'h0F;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/timing_sequence_scheduler_slot_position_counter.sv
// Cumulative DRAM-cycle position of the sequence being loaded. Exposes the
// frame/slot/overflow of the candidate position pos + max(tp, 1).
module timing_sequence_scheduler_slot_position_counter
  import timing_sequence_scheduler_pkg::*;
#(
  parameter int nCK_PER_CLK = 4,
  parameter int TP_W        = 4,
  parameter int DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          step,
  input  logic [TP_W-1:0]               tp,
  output logic [clog2(DEPTH)-1:0]       frame,
  output logic [clog2(nCK_PER_CLK)-1:0] slot,
  output logic                          overflow
);

  localparam int PW  = clog2(DEPTH * nCK_PER_CLK) + 1;
  localparam int SW  = PW + TP_W;
  localparam int FW  = clog2(DEPTH);
  localparam int SLW = clog2(nCK_PER_CLK);

  logic [PW-1:0]   pos_reg;
  logic [TP_W-1:0] tp_eff;
  logic [SW-1:0]   sum;

  // A zero spacing would collide with the previous slot, so it advances by one.
  assign tp_eff   = (tp == '0) ? TP_W'(1) : tp;
  assign sum      = SW'(pos_reg) + SW'(tp_eff);
  assign overflow = (sum >= SW'(DEPTH * nCK_PER_CLK));
  assign frame    = sum[SLW +: FW];
  assign slot     = sum[SLW-1:0];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pos_reg <= '0;
    end else if (step && !overflow) begin
      pos_reg <= sum[PW-1:0];
    end
  end

endmodule

// File: rtl/timing_sequence_scheduler.sv
// Packs a DRAM command sequence into nCK_PER_CLK-slot PHY frames and replays them
// back-to-back. Optional macro SCHED_LOOP_EN adds loop_cnt for repeated playback.
module timing_sequence_scheduler
  import timing_sequence_scheduler_pkg::*;
#(
  parameter int               nCK_PER_CLK = 4,
  parameter int               CMD_W       = 8,
  parameter int               TP_W        = 4,
  parameter int               DEPTH       = 16,
  parameter logic [CMD_W-1:0] NOP_CMD     = CMD_W'(NOP_CMD_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef SCHED_LOOP_EN
  input  logic [7:0]                   loop_cnt,
`endif
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [CMD_W-1:0]             cmd_data,
  input  logic [TP_W-1:0]              cmd_tp,
  input  logic                         cmd_last,
  output logic                         phy_valid,
  output logic [nCK_PER_CLK*CMD_W-1:0] phy_cmd,
  output logic [nCK_PER_CLK-1:0]       phy_slot_vld,
  output logic                         seq_done,
  output logic                         seq_err,
  output logic                         busy
);

  localparam int FW  = clog2(DEPTH);
  localparam int SLW = clog2(nCK_PER_CLK);
  localparam logic [nCK_PER_CLK*CMD_W-1:0] NOP_FRAME = {nCK_PER_CLK{NOP_CMD}};

  state_t state_reg, state_next;
  logic [FW-1:0] last_frame_reg, last_frame_next;
  logic [FW-1:0] play_frame_reg, play_frame_next;
  logic [7:0]    loop_rem_reg, loop_rem_next;
  logic          phy_valid_reg;
  logic [nCK_PER_CLK*CMD_W-1:0] phy_cmd_reg;
  logic [nCK_PER_CLK-1:0]       slot_vld_reg;
  logic          seq_done_reg, seq_err_reg, seq_err_next;

  logic [CMD_W-1:0]       cmd_mem [DEPTH][nCK_PER_CLK];
  logic [nCK_PER_CLK-1:0] vld_mem [DEPTH];

  logic           xfer, enter_play, final_pass, load_frame;
  logic           wr_en, clear_vld;
  logic [FW-1:0]  wr_frame, rd_frame, cnt_frame;
  logic [SLW-1:0] wr_slot, cnt_slot;
  logic           cnt_overflow;
  logic [nCK_PER_CLK*CMD_W-1:0] rd_data;
  logic [nCK_PER_CLK-1:0]       rd_vld, byp;

  assign cmd_ready    = (state_reg != PLAY);
  assign busy         = (state_reg != IDLE);
  assign xfer         = cmd_valid && cmd_ready;
  assign phy_valid    = phy_valid_reg;
  assign phy_cmd      = phy_cmd_reg;
  assign phy_slot_vld = slot_vld_reg;
  assign seq_done     = seq_done_reg;
  assign seq_err      = seq_err_reg;

  timing_sequence_scheduler_slot_position_counter #(
    .nCK_PER_CLK (nCK_PER_CLK),
    .TP_W        (TP_W),
    .DEPTH       (DEPTH)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .clear    (xfer && (state_reg == IDLE)),
    .step     (xfer && (state_reg == LOAD)),
    .tp       (cmd_tp),
    .frame    (cnt_frame),
    .slot     (cnt_slot),
    .overflow (cnt_overflow)
  );

  always_comb begin
    state_next      = state_reg;
    last_frame_next = last_frame_reg;
    play_frame_next = play_frame_reg;
    loop_rem_next   = loop_rem_reg;
    seq_err_next    = 1'b0;
    wr_en           = 1'b0;
    wr_frame        = cnt_frame;
    wr_slot         = cnt_slot;
    clear_vld       = 1'b0;
    enter_play      = 1'b0;
    load_frame      = 1'b0;
    rd_frame        = '0;
    final_pass      = 1'b1;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          clear_vld       = 1'b1;
          wr_en           = 1'b1;
          wr_frame        = '0;
          wr_slot         = '0;
          last_frame_next = '0;
          state_next      = LOAD;
          enter_play      = cmd_last;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (cnt_overflow) begin
            seq_err_next = 1'b1;
            state_next   = cmd_last ? IDLE : DRAIN;
          end else begin
            wr_en           = 1'b1;
            last_frame_next = cnt_frame;
            enter_play      = cmd_last;
          end
        end
      end
      DRAIN: begin
        if (xfer && cmd_last) state_next = IDLE;
      end
      PLAY: begin
        if (play_frame_reg == last_frame_reg) begin
          if (loop_rem_reg != 8'd0) begin
            load_frame      = 1'b1;
            play_frame_next = '0;
            loop_rem_next   = loop_rem_reg - 8'd1;
            final_pass      = (loop_rem_reg == 8'd1);
          end else begin
            state_next = IDLE;
          end
        end else begin
          load_frame      = 1'b1;
          rd_frame        = play_frame_reg + FW'(1);
          play_frame_next = play_frame_reg + FW'(1);
          final_pass      = (loop_rem_reg == 8'd0);
        end
      end
      default: state_next = IDLE;
    endcase
    if (enter_play) begin
      state_next      = PLAY;
      load_frame      = 1'b1;
      play_frame_next = '0;
`ifdef SCHED_LOOP_EN
      loop_rem_next   = loop_cnt;
      final_pass      = (loop_cnt == 8'd0);
`else
      loop_rem_next   = 8'd0;
      final_pass      = 1'b1;
`endif
    end
  end

  // Frame 0 can be read in the same cycle its last command is written, so
  // the write port is forwarded into the read path slot by slot.
  for (genvar gi = 0; gi < nCK_PER_CLK; gi++) begin : g_slot
    assign byp[gi]    = wr_en && (wr_frame == rd_frame) && (wr_slot == SLW'(gi));
    assign rd_vld[gi] = byp[gi] || (!clear_vld && vld_mem[rd_frame][gi]);
    assign rd_data[gi*CMD_W +: CMD_W] =
      byp[gi] ? cmd_data : (rd_vld[gi] ? cmd_mem[rd_frame][gi] : NOP_CMD);
  end

  always_ff @(posedge clk) begin
    if (wr_en) cmd_mem[wr_frame][wr_slot] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear_vld) begin
      for (int f = 0; f < DEPTH; f++) vld_mem[f] <= '0;
    end
    if (!rst && wr_en) vld_mem[wr_frame][wr_slot] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_frame_reg <= '0;
      play_frame_reg <= '0;
      loop_rem_reg   <= 8'd0;
      phy_valid_reg  <= 1'b0;
      phy_cmd_reg    <= NOP_FRAME;
      slot_vld_reg   <= '0;
      seq_done_reg   <= 1'b0;
      seq_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_frame_reg <= last_frame_next;
      play_frame_reg <= play_frame_next;
      loop_rem_reg   <= loop_rem_next;
      phy_valid_reg  <= load_frame;
      phy_cmd_reg    <= load_frame ? rd_data : NOP_FRAME;
      slot_vld_reg   <= load_frame ? rd_vld : '0;
      seq_done_reg   <= load_frame && final_pass && (rd_frame == last_frame_next);
      seq_err_reg    <= seq_err_next;
    end
  end

endmodule

// File: tb/tb_timing_sequence_scheduler.sv
// Directed bench for timing_sequence_scheduler: frame packing, spacing, overflow,
// mid-play reset and back-to-back sequences with hand-computed frames.
module tb_timing_sequence_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_last;
  logic [7:0]  cmd_data;
  logic [3:0]  cmd_tp;
  logic        phy_valid, seq_done, seq_err, busy;
  logic [31:0] phy_cmd;
  logic [3:0]  phy_slot_vld;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rec_cmd [$];
  logic [3:0]  rec_vld [$];
  logic        rec_done [$];
  int          rec_first;

  always #5 clk = ~clk;

  timing_sequence_scheduler dut (
    .clk          (clk),
    .rst          (rst),
`ifdef SCHED_LOOP_EN
    .loop_cnt     (8'd0),
`endif
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_data     (cmd_data),
    .cmd_tp       (cmd_tp),
    .cmd_last     (cmd_last),
    .phy_valid    (phy_valid),
    .phy_cmd      (phy_cmd),
    .phy_slot_vld (phy_slot_vld),
    .seq_done     (seq_done),
    .seq_err      (seq_err),
    .busy         (busy)
  );

  task automatic send(input logic [7:0] d, input logic [3:0] tp, input logic last);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_tp    = tp;
    cmd_last  = last;
    $display("send cmd=%h tp=%0d last=%b", d, tp, last);
  endtask

  task automatic record(input int budget);
    bit seen;
    seen = 0;
    rec_first = -1;
    rec_cmd.delete();
    rec_vld.delete();
    rec_done.delete();
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
      if (phy_valid === 1'b1) begin
        if (!seen) rec_first = c;
        seen = 1;
        rec_cmd.push_back(phy_cmd);
        rec_vld.push_back(phy_slot_vld);
        rec_done.push_back(seq_done);
        $display("frame %0d cmd=%h vld=%b done=%b", rec_cmd.size() - 1, phy_cmd, phy_slot_vld, seq_done);
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic settle();
    repeat (3) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
    end
  endtask

  task automatic test_reset();
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    n_cmp++; if (phy_valid !== 1'b0) begin n_bad++; $display("FAIL reset_phy_valid got %b want 0", phy_valid); end
    n_cmp++; if (phy_cmd !== 32'h0F0F0F0F) begin n_bad++; $display("FAIL reset_phy_cmd got %h want 0f0f0f0f", phy_cmd); end
    n_cmp++; if (phy_slot_vld !== 4'b0000) begin n_bad++; $display("FAIL reset_slot_vld got %b want 0000", phy_slot_vld); end
    n_cmp++; if (seq_done !== 1'b0) begin n_bad++; $display("FAIL reset_seq_done got %b want 0", seq_done); end
    n_cmp++; if (seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq_err got %b want 0", seq_err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_full_frame();
    send(8'hA1, 4'd9, 1'b0);
    send(8'hB2, 4'd1, 1'b0);
    send(8'hC3, 4'd1, 1'b0);
    send(8'hD4, 4'd1, 1'b1);
    record(20);
    n_cmp++; if (rec_cmd.size() !== 1) begin n_bad++; $display("FAIL full_count got %0d want 1", rec_cmd.size()); end
    n_cmp++; if (rec_first !== 0) begin n_bad++; $display("FAIL full_latency got %0d want 0", rec_first); end
    n_cmp++; if (rec_cmd[0] !== 32'hD4C3B2A1) begin n_bad++; $display("FAIL full_cmd got %h want d4c3b2a1", rec_cmd[0]); end
    n_cmp++; if (rec_vld[0] !== 4'b1111) begin n_bad++; $display("FAIL full_vld got %b want 1111", rec_vld[0]); end
    n_cmp++; if (rec_done[0] !== 1'b1) begin n_bad++; $display("FAIL full_done got %b want 1", rec_done[0]); end
    settle();
  endtask

  task automatic test_gap();
    send(8'hA1, 4'd0, 1'b0);
    send(8'hB2, 4'd6, 1'b1);
    record(20);
    n_cmp++; if (rec_cmd.size() !== 2) begin n_bad++; $display("FAIL gap_count got %0d want 2", rec_cmd.size()); end
    n_cmp++; if (rec_cmd[0] !== 32'h0F0F0FA1) begin n_bad++; $display("FAIL gap_f0_cmd got %h want 0f0f0fa1", rec_cmd[0]); end
    n_cmp++; if (rec_vld[0] !== 4'b0001) begin n_bad++; $display("FAIL gap_f0_vld got %b want 0001", rec_vld[0]); end
    n_cmp++; if (rec_done[0] !== 1'b0) begin n_bad++; $display("FAIL gap_f0_done got %b want 0", rec_done[0]); end
    n_cmp++; if (rec_cmd[1] !== 32'h0FB20F0F) begin n_bad++; $display("FAIL gap_f1_cmd got %h want 0fb20f0f", rec_cmd[1]); end
    n_cmp++; if (rec_vld[1] !== 4'b0100) begin n_bad++; $display("FAIL gap_f1_vld got %b want 0100", rec_vld[1]); end
    n_cmp++; if (rec_done[1] !== 1'b1) begin n_bad++; $display("FAIL gap_f1_done got %b want 1", rec_done[1]); end
    settle();
  endtask

  task automatic test_tp_zero();
    send(8'hA1, 4'd3, 1'b0);
    send(8'hB2, 4'd0, 1'b1);
    record(20);
    n_cmp++; if (rec_cmd.size() !== 1) begin n_bad++; $display("FAIL tp0_count got %0d want 1", rec_cmd.size()); end
    n_cmp++; if (rec_cmd[0] !== 32'h0F0FB2A1) begin n_bad++; $display("FAIL tp0_cmd got %h want 0f0fb2a1", rec_cmd[0]); end
    n_cmp++; if (rec_vld[0] !== 4'b0011) begin n_bad++; $display("FAIL tp0_vld got %b want 0011", rec_vld[0]); end
    settle();
  endtask

  task automatic test_max_pos();
    // positions 0,15,30,45,60,63 -> frames 0,3,7,11,15,15
    send(8'hA1, 4'd0, 1'b0);
    send(8'hE1, 4'd15, 1'b0);
    send(8'hE2, 4'd15, 1'b0);
    send(8'hE3, 4'd15, 1'b0);
    send(8'hE4, 4'd15, 1'b0);
    send(8'hF9, 4'd3, 1'b1);
    record(40);
    n_cmp++; if (rec_cmd.size() !== 16) begin n_bad++; $display("FAIL max_count got %0d want 16", rec_cmd.size()); end
    n_cmp++; if (rec_cmd[3] !== 32'hE10F0F0F) begin n_bad++; $display("FAIL max_f3_cmd got %h want e10f0f0f", rec_cmd[3]); end
    n_cmp++; if (rec_vld[7] !== 4'b0100) begin n_bad++; $display("FAIL max_f7_vld got %b want 0100", rec_vld[7]); end
    n_cmp++; if (rec_done[14] !== 1'b0) begin n_bad++; $display("FAIL max_f14_done got %b want 0", rec_done[14]); end
    n_cmp++; if (rec_cmd[15] !== 32'hF90F0FE4) begin n_bad++; $display("FAIL max_f15_cmd got %h want f90f0fe4", rec_cmd[15]); end
    n_cmp++; if (rec_vld[15] !== 4'b1001) begin n_bad++; $display("FAIL max_f15_vld got %b want 1001", rec_vld[15]); end
    n_cmp++; if (rec_done[15] !== 1'b1) begin n_bad++; $display("FAIL max_f15_done got %b want 1", rec_done[15]); end
    settle();
  endtask

  task automatic test_overflow();
    logic [3:0] tps [8];
    int err_cnt, err_at, rdy_low, pv_cnt;
    logic busy_drain;
    tps = '{4'd0, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd1, 4'd1};
    err_cnt = 0; err_at = -1; rdy_low = 0; pv_cnt = 0; busy_drain = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (seq_err === 1'b1) begin err_cnt++; err_at = k; end
      if (cmd_ready !== 1'b1) rdy_low++;
      if (phy_valid !== 1'b0) pv_cnt++;
      if (k == 7) busy_drain = busy;
      if (k < 8) begin
        cmd_valid = 1'b1;
        cmd_data  = 8'h10 + 8'(k);
        cmd_tp    = tps[k];
        cmd_last  = (k == 7);
        $display("send cmd=%h tp=%0d last=%b ready=%b err=%b", cmd_data, cmd_tp, cmd_last, cmd_ready, seq_err);
      end else begin
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
      end
    end
    n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL ovf_err_pulses got %0d want 1", err_cnt); end
    n_cmp++; if (err_at !== 6) begin n_bad++; $display("FAIL ovf_err_cycle got %0d want 6", err_at); end
    n_cmp++; if (rdy_low !== 0) begin n_bad++; $display("FAIL ovf_ready_low got %0d want 0", rdy_low); end
    n_cmp++; if (pv_cnt !== 0) begin n_bad++; $display("FAIL ovf_phy_valid got %0d want 0", pv_cnt); end
    n_cmp++; if (busy_drain !== 1'b1) begin n_bad++; $display("FAIL ovf_busy_drain got %b want 1", busy_drain); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ovf_busy_end got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int pv_after;
    logic pv_f2;
    pv_after = 0;
    pv_f2 = 1'b0;
    send(8'hA1, 4'd0, 1'b0);
    send(8'hB2, 4'd15, 1'b0);
    send(8'hC3, 4'd2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_last  = 1'b0;
      if (c == 2) begin
        pv_f2 = phy_valid;
        rst = 1'b1;
        $display("reset during frame 2 cmd=%h", phy_cmd);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (pv_f2 !== 1'b1) begin n_bad++; $display("FAIL rmid_frame2_valid got %b want 1", pv_f2); end
    n_cmp++; if (phy_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_phy_valid got %b want 0", phy_valid); end
    n_cmp++; if (phy_cmd !== 32'h0F0F0F0F) begin n_bad++; $display("FAIL rmid_phy_cmd got %h want 0f0f0f0f", phy_cmd); end
    n_cmp++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got %b want 1", cmd_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %b want 0", busy); end
    repeat (5) begin
      @(negedge clk);
      if (phy_valid !== 1'b0) pv_after++;
    end
    n_cmp++; if (pv_after !== 0) begin n_bad++; $display("FAIL rmid_no_more_frames got %0d want 0", pv_after); end
  endtask

  task automatic test_back_to_back();
    logic r2, r3, r4, pv4;
    send(8'hA1, 4'd0, 1'b0);
    send(8'hB2, 4'd4, 1'b1);
    @(negedge clk);                       // frame 0 shown
    cmd_valid = 1'b1; cmd_data = 8'hE5; cmd_tp = 4'd0; cmd_last = 1'b1;
    r2 = cmd_ready;
    @(negedge clk);                       // frame 1 shown, seq_done
    r3 = cmd_ready;
    n_cmp++; if (seq_done !== 1'b1) begin n_bad++; $display("FAIL b2b_done got %b want 1", seq_done); end
    @(negedge clk);                       // IDLE: E accepted at next edge
    r4 = cmd_ready;
    pv4 = phy_valid;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_last = 1'b0;
    $display("b2b frame cmd=%h vld=%b done=%b", phy_cmd, phy_slot_vld, seq_done);
    n_cmp++; if (r2 !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_f0 got %b want 0", r2); end
    n_cmp++; if (r3 !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_f1 got %b want 0", r3); end
    n_cmp++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_idle got %b want 1", r4); end
    n_cmp++; if (pv4 !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid got %b want 0", pv4); end
    n_cmp++; if (phy_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_new_valid got %b want 1", phy_valid); end
    n_cmp++; if (phy_cmd !== 32'h0F0F0FE5) begin n_bad++; $display("FAIL b2b_new_cmd got %h want 0f0f0fe5", phy_cmd); end
    n_cmp++; if (phy_slot_vld !== 4'b0001) begin n_bad++; $display("FAIL b2b_new_vld got %b want 0001", phy_slot_vld); end
    settle();
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_data = 8'h00; cmd_tp = 4'd0; cmd_last = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_full_frame();
    test_gap();
    test_tp_zero();
    test_max_pos();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
